// File: rtl/mem_responder_if.sv
// Request/response bus between the data cache (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] cache2mem_addr;
    logic [XLEN-1:0] cache2mem_data;
    logic [2:0]      cache2mem_size;
    logic [1:0]      cache2mem_command;
    logic [3:0]      mem2cache_response;
    logic [XLEN-1:0] mem2cache_data;
    logic [3:0]      mem2cache_tag;

    modport master (
        output cache2mem_addr, cache2mem_data, cache2mem_size, cache2mem_command,
        input  mem2cache_response, mem2cache_data, mem2cache_tag
    );

    modport slave (
        input  cache2mem_addr, cache2mem_data, cache2mem_size, cache2mem_command,
        output mem2cache_response, mem2cache_data, mem2cache_tag
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: word-addressed storage, same-cycle tagged acceptance and
// fixed-latency in-order load returns through a LATENCY-deep valid pipe.
module mem_responder #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned LATENCY         = 6,
    parameter int unsigned NUM_OUTSTANDING = 4,
    parameter int unsigned MEM_WORDS       = 1024
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = $clog2(NUM_OUTSTANDING + 1);

    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [XLEN-1:0]    r_mem [MEM_WORDS];

    logic [LATENCY-1:0] r_pv;
    logic [3:0]         r_ptag  [LATENCY];
    logic [XLEN-1:0]    r_pdata [LATENCY];
    logic [CW-1:0]      r_count;
    logic [3:0]         r_next_tag;
    logic [3:0]         r_out_tag;
    logic [XLEN-1:0]    r_out_data;

    logic            w_is_load;
    logic            w_is_store;
    logic            w_size_ok;
    logic            w_misaligned;
    logic            w_retire;
    logic            w_full;
    logic            w_accept;
    logic            w_push;
    logic            w_write;
    logic            w_in_range;
    logic [AW-1:0]   w_idx;
    logic [XLEN-1:0] w_rd_word;

    always_comb begin
        w_is_load    = (bus.cache2mem_command == BUS_LOAD);
        w_is_store   = (bus.cache2mem_command == BUS_STORE);
        w_size_ok    = (bus.cache2mem_size[1:0] != 2'b11);
        w_misaligned = ((bus.cache2mem_size[1:0] == 2'b01) && bus.cache2mem_addr[0]) ||
                       ((bus.cache2mem_size[1:0] == 2'b10) && (bus.cache2mem_addr[1:0] != 2'b00));
        // A load leaving the pipe this edge frees its slot for a load accepted on the same edge.
        w_retire     = r_pv[LATENCY-1];
        w_full       = (r_count == CW'(NUM_OUTSTANDING)) && !w_retire;
        w_accept     = rst && w_size_ok && !w_misaligned &&
                       (w_is_store || (w_is_load && !w_full));
        w_push       = w_accept && w_is_load;
        w_in_range   = ({2'b00, bus.cache2mem_addr[XLEN-1:2]} < XLEN'(MEM_WORDS));
        w_write      = w_accept && w_is_store && w_in_range;
        w_idx        = bus.cache2mem_addr[AW+1:2];
        w_rd_word    = w_in_range ? r_mem[w_idx] : '0;
        bus.mem2cache_response = w_accept ? r_next_tag : 4'd0;
        bus.mem2cache_tag      = r_out_tag;
        bus.mem2cache_data     = r_out_data;
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_write) begin
            unique case (bus.cache2mem_size[1:0])
                2'b00:   r_mem[w_idx][{bus.cache2mem_addr[1:0], 3'b000} +: 8] <=
                             bus.cache2mem_data[7:0];
                2'b01:   r_mem[w_idx][{bus.cache2mem_addr[1], 4'b0000} +: 16] <=
                             bus.cache2mem_data[15:0];
                2'b10:   r_mem[w_idx] <= bus.cache2mem_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pv <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_ptag[i]  <= '0;
                r_pdata[i] <= '0;
            end
            r_count    <= '0;
            r_next_tag <= 4'd1;
            r_out_tag  <= '0;
            r_out_data <= '0;
        end else begin
            r_pv[0]    <= w_push;
            r_ptag[0]  <= r_next_tag;
            r_pdata[0] <= w_rd_word;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_ptag[i]  <= r_ptag[i-1];
                r_pdata[i] <= r_pdata[i-1];
            end
            r_out_tag <= w_retire ? r_ptag[LATENCY-1] : 4'd0;
            if (w_retire) begin
                r_out_data <= r_pdata[LATENCY-1];
            end
            r_count <= r_count + CW'(w_push) - CW'(w_retire);
            if (w_accept) begin
                r_next_tag <= (r_next_tag == 4'd15) ? 4'd1 : r_next_tag + 4'd1;
            end
        end
    end
endmodule
